// File: rtl/usb_sniffer_utmi_capture_pkg.sv
// -----------------------------------------------------------------------------
// usb_sniffer_utmi_capture_pkg
// Shared definitions for the UTMI capture block: word-type codes, field bit
// positions, output FIFO depth, counter widths, the capture FSM state type and
// helpers that build each of the four output word formats.
// -----------------------------------------------------------------------------
package usb_sniffer_utmi_capture_pkg;

  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  // Word type lives in [31:30]
  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;

  localparam logic [1:0] TYPE_DATA = 2'b00;
  localparam logic [1:0] TYPE_LS   = 2'b01;
  localparam logic [1:0] TYPE_HDR  = 2'b10;
  localparam logic [1:0] TYPE_END  = 2'b11;

  localparam int DIR_BIT   = 29;  // HDR: 1 = TX
  localparam int DCNT_HI   = 29;  // DATA: byte count
  localparam int DCNT_LO   = 28;
  localparam int ERR_BIT   = 29;  // END: rxerror seen
  localparam int TRUNC_BIT = 28;  // END: packet lost words
  localparam int LS_HI     = 17;  // HDR/LS: linestate
  localparam int LS_LO     = 16;
  localparam int BYTES_W   = 24;  // DATA: packed bytes, first in [7:0]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX,
    ST_FLUSH,
    ST_END
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [WORD_W-1:0] mk_hdr(input logic dir, input logic [1:0] ls,
                                               input logic [CNT_W-1:0] delta);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[TYPE_HI:TYPE_LO] = TYPE_HDR;
    w[DIR_BIT]         = dir;
    w[LS_HI:LS_LO]     = ls;
    w[CNT_W-1:0]       = delta;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] mk_ls(input logic [1:0] ls,
                                              input logic [CNT_W-1:0] delta);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[TYPE_HI:TYPE_LO] = TYPE_LS;
    w[LS_HI:LS_LO]     = ls;
    w[CNT_W-1:0]       = delta;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] mk_data(input logic [1:0] cnt,
                                                input logic [BYTES_W-1:0] bytes);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[TYPE_HI:TYPE_LO] = TYPE_DATA;
    w[DCNT_HI:DCNT_LO] = cnt;
    w[BYTES_W-1:0]     = bytes;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] mk_end(input logic err, input logic trunc,
                                               input logic [CNT_W-1:0] nbytes);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[TYPE_HI:TYPE_LO] = TYPE_END;
    w[ERR_BIT]         = err;
    w[TRUNC_BIT]       = trunc;
    w[CNT_W-1:0]       = nbytes;
    return w;
  endfunction

endpackage

// File: rtl/usb_sniffer_utmi_capture_if.sv
// -----------------------------------------------------------------------------
// usb_sniffer_utmi_capture_if
// Bundles the UTMI monitor inputs and the 32-bit capture stream output.
//   slave  : the capture block (consumes UTMI, drives the stream)
//   master : the environment (drives UTMI and tready, observes the stream)
// -----------------------------------------------------------------------------
interface usb_sniffer_utmi_capture_if;
  import usb_sniffer_utmi_capture_pkg::*;

  logic [7:0]        utmi_data_in_i;
  logic [7:0]        utmi_data_out_i;
  logic              utmi_txvalid_i;
  logic              utmi_txready_i;
  logic              utmi_rxvalid_i;
  logic              utmi_rxactive_i;
  logic              utmi_rxerror_i;
  logic [1:0]        utmi_linestate_i;
  logic              outport_tvalid_o;
  logic [WORD_W-1:0] outport_tdata_o;
  logic              outport_tready_i;

  modport master (
    output utmi_data_in_i, utmi_data_out_i, utmi_txvalid_i, utmi_txready_i,
    output utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i, utmi_linestate_i,
    output outport_tready_i,
    input  outport_tvalid_o, outport_tdata_o
  );

  modport slave (
    input  utmi_data_in_i, utmi_data_out_i, utmi_txvalid_i, utmi_txready_i,
    input  utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i, utmi_linestate_i,
    input  outport_tready_i,
    output outport_tvalid_o, outport_tdata_o
  );

endinterface

// File: rtl/usb_sniffer_capture_fifo.sv
// -----------------------------------------------------------------------------
// usb_sniffer_capture_fifo
// Small synchronous FIFO in front of the AXI-Stream output.
//   push_i/data_i : write request; written only when accept_o is high
//   accept_o      : space available this cycle (a pop on a full FIFO frees it)
//   valid_o/data_o: head entry, held stable until popped
//   pop_i         : consumer ready; pops when valid_o is high
// -----------------------------------------------------------------------------
module usb_sniffer_capture_fifo
  import usb_sniffer_utmi_capture_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             accept_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             pop_i
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [PW:0]      cnt_q;
  logic             do_pop, do_push;

  assign valid_o  = (cnt_q != '0);
  assign do_pop   = pop_i & valid_o;
  assign accept_o = (cnt_q != (PW+1)'(DEPTH)) | do_pop;
  assign do_push  = push_i & accept_o;
  assign data_o   = mem_q[rd_q];

  // Memory is reset too so the stream data reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/usb_sniffer_utmi_capture.sv
// -----------------------------------------------------------------------------
// usb_sniffer_utmi_capture
// Watches a UTMI link and turns packets and linestate changes into a stream of
// 32-bit words (HDR / DATA / END / LS) on an AXI-Stream style output.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   bus (slave)       : UTMI monitor inputs and the outport_* stream
//   cfg_enable_i      : allows new HDR/LS words; never aborts a running packet
//   cfg_clr_stats_i   : clears the statistics (wins over an increment)
//   stat_dropped_o    : saturating count of words lost to a full FIFO
//   stat_overflow_o   : sticky flag, set on any drop
// -----------------------------------------------------------------------------
module usb_sniffer_utmi_capture
  import usb_sniffer_utmi_capture_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  usb_sniffer_utmi_capture_if.slave bus,
  input  logic                      cfg_enable_i,
  input  logic                      cfg_clr_stats_i,
  output logic [CNT_W-1:0]          stat_dropped_o,
  output logic                      stat_overflow_o
);
  state_e            state_q, state_d;
  logic              rxa_prev_q, txv_prev_q;
  logic [1:0]        ls_last_q, ls_last_d;
  logic [CNT_W-1:0]  delta_q, delta_d, pkt_cnt_q, pkt_cnt_d, dropped_q, dropped_d;
  logic              rxerr_q, rxerr_d, trunc_q, trunc_d, ovf_q, ovf_d;
  logic [1:0]        pk_cnt_q, pk_cnt_d;
  logic [15:0]       pk_buf_q, pk_buf_d;
  logic              rx_start, tx_start, push, push_is_end, accept, drop, clr_delta, cap;
  logic [7:0]        cap_byte;
  logic [WORD_W-1:0] push_word;

  assign rx_start = bus.utmi_rxactive_i & ~rxa_prev_q;
  assign tx_start = bus.utmi_txvalid_i & ~txv_prev_q;

  always_comb begin
    state_d     = state_q;
    ls_last_d   = ls_last_q;
    pkt_cnt_d   = pkt_cnt_q;
    rxerr_d     = rxerr_q;
    trunc_d     = trunc_q;
    pk_cnt_d    = pk_cnt_q;
    pk_buf_d    = pk_buf_q;
    push        = 1'b0;
    push_is_end = 1'b0;
    push_word   = '0;
    clr_delta   = 1'b0;
    cap         = 1'b0;
    cap_byte    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable_i) begin
          if (rx_start || tx_start) begin
            // RX wins when both links start in the same cycle
            push      = 1'b1;
            push_word = mk_hdr(~rx_start, bus.utmi_linestate_i, delta_q);
            clr_delta = 1'b1;
            state_d   = rx_start ? ST_RX : ST_TX;
            pkt_cnt_d = '0;
            rxerr_d   = 1'b0;
            trunc_d   = 1'b0;
            pk_cnt_d  = '0;
            pk_buf_d  = '0;
          end else if (bus.utmi_linestate_i != ls_last_q) begin
            push      = 1'b1;
            push_word = mk_ls(bus.utmi_linestate_i, delta_q);
            clr_delta = 1'b1;
            ls_last_d = bus.utmi_linestate_i;
          end
        end
      end
      ST_RX: begin
        rxerr_d  = rxerr_q | bus.utmi_rxerror_i;
        cap      = bus.utmi_rxvalid_i & bus.utmi_rxactive_i;
        cap_byte = bus.utmi_data_in_i;
        if (!bus.utmi_rxactive_i) state_d = ST_FLUSH;
      end
      ST_TX: begin
        cap      = bus.utmi_txvalid_i & bus.utmi_txready_i;
        cap_byte = bus.utmi_data_out_i;
        if (!bus.utmi_txvalid_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pk_cnt_q != 2'd0) begin
          push      = 1'b1;
          push_word = mk_data(pk_cnt_q, {8'h00, pk_buf_q});
        end
        pk_cnt_d = '0;
        pk_buf_d = '0;
        state_d  = ST_END;
      end
      ST_END: begin
        // The END word waits here for space rather than being dropped
        push        = 1'b1;
        push_is_end = 1'b1;
        push_word   = mk_end(rxerr_q, trunc_q, pkt_cnt_q);
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte packer: the third byte goes straight into the word, not the buffer
    if (cap) begin
      pkt_cnt_d = sat_inc(pkt_cnt_q);
      if (pk_cnt_q == 2'd2) begin
        push      = 1'b1;
        push_word = mk_data(2'd3, {cap_byte, pk_buf_q});
        pk_cnt_d  = '0;
        pk_buf_d  = '0;
      end else begin
        if (pk_cnt_q == 2'd0) pk_buf_d[7:0]  = cap_byte;
        else                  pk_buf_d[15:8] = cap_byte;
        pk_cnt_d = pk_cnt_q + 2'd1;
      end
    end

    drop = push & ~push_is_end & ~accept;
    if (drop) trunc_d = 1'b1;

    delta_d = clr_delta ? '0 : sat_inc(delta_q);

    dropped_d = dropped_q;
    ovf_d     = ovf_q;
    if (cfg_clr_stats_i) begin
      dropped_d = '0;
      ovf_d     = 1'b0;
    end else if (drop) begin
      dropped_d = sat_inc(dropped_q);
      ovf_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rxa_prev_q <= 1'b0;
      txv_prev_q <= 1'b0;
      ls_last_q  <= '0;
      delta_q    <= '0;
      pkt_cnt_q  <= '0;
      rxerr_q    <= 1'b0;
      trunc_q    <= 1'b0;
      pk_cnt_q   <= '0;
      pk_buf_q   <= '0;
      dropped_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ls_last_q <= ls_last_d;
      delta_q   <= delta_d;
      pkt_cnt_q <= pkt_cnt_d;
      rxerr_q   <= rxerr_d;
      trunc_q   <= trunc_d;
      pk_cnt_q  <= pk_cnt_d;
      pk_buf_q  <= pk_buf_d;
      dropped_q <= dropped_d;
      ovf_q     <= ovf_d;
      // Frozen in FLUSH/END so a start arriving there is still seen as an
      // edge once the FSM is back in IDLE.
      if (state_q != ST_FLUSH && state_q != ST_END) begin
        rxa_prev_q <= bus.utmi_rxactive_i;
        txv_prev_q <= bus.utmi_txvalid_i;
      end
    end
  end

  usb_sniffer_capture_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push),
    .data_i   (push_word),
    .accept_o (accept),
    .valid_o  (bus.outport_tvalid_o),
    .data_o   (bus.outport_tdata_o),
    .pop_i    (bus.outport_tready_i)
  );

  assign stat_dropped_o  = dropped_q;
  assign stat_overflow_o = ovf_q;

endmodule

// File: tb/tb_usb_sniffer_utmi_capture.sv
// -----------------------------------------------------------------------------
// tb_usb_sniffer_utmi_capture
// Directed scenarios plus randomized UTMI traffic, checked every cycle against
// a word-level reference model (byte queue, FIFO queue, packet phase).
// -----------------------------------------------------------------------------
module tb_usb_sniffer_utmi_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en, clr;
  logic [15:0] stat_dropped;
  logic        stat_ovf;

  usb_sniffer_utmi_capture_if bus ();

  usb_sniffer_utmi_capture dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .bus             (bus),
    .cfg_enable_i    (en),
    .cfg_clr_stats_i (clr),
    .stat_dropped_o  (stat_dropped),
    .stat_overflow_o (stat_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_mode = 0;

  // Reference model state
  localparam int P_IDLE = 0, P_RX = 1, P_TX = 2, P_FLUSH = 3, P_END = 4;
  int          m_phase;
  bit          m_prxa, m_ptxv;
  logic [1:0]  m_last;
  int          m_delta, m_cnt, m_drop;
  bit          m_err, m_trunc, m_ovf, m_dropnow;
  logic [7:0]  m_bytes[$];
  logic [31:0] mq[$];
  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] gw(input int i);
    return (i < got.size()) ? got[i] : 32'hDEADBEEF;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_prxa = 0; m_ptxv = 0; m_last = 2'b00;
    m_delta = 0; m_cnt = 0; m_drop = 0; m_err = 0; m_trunc = 0; m_ovf = 0;
    m_bytes.delete(); mq.delete();
  endtask

  task automatic mpush(input logic [31:0] w);
    if (mq.size() < 4) mq.push_back(w);
    else begin
      m_dropnow = 1;
      m_trunc   = 1;
    end
  endtask

  function automatic logic [31:0] data_word();
    logic [23:0] b = '0;
    for (int i = 0; i < m_bytes.size(); i++) b[i*8 +: 8] = m_bytes[i];
    return {2'b00, 2'(m_bytes.size()), 4'b0000, b};
  endfunction

  task automatic capture(input logic [7:0] b);
    m_bytes.push_back(b);
    if (m_cnt < 65535) m_cnt++;
    if (m_bytes.size() == 3) begin
      mpush(data_word());
      m_bytes.delete();
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_eval();
    bit rxa, txv, rs, ts, mark;
    int ph0;
    rxa = bus.utmi_rxactive_i;
    txv = bus.utmi_txvalid_i;
    rs  = rxa && !m_prxa;
    ts  = txv && !m_ptxv;
    ph0 = m_phase;
    mark = 0;
    m_dropnow = 0;
    if (mq.size() > 0 && bus.outport_tready_i) void'(mq.pop_front());
    case (m_phase)
      P_IDLE: if (en) begin
        if (rs || ts) begin
          m_bytes.delete(); m_cnt = 0; m_err = 0; m_trunc = 0;
          mpush({2'b10, !rs, 11'b0, bus.utmi_linestate_i, 16'(m_delta)});
          mark = 1;
          m_phase = rs ? P_RX : P_TX;
        end else if (bus.utmi_linestate_i != m_last) begin
          mpush({2'b01, 12'b0, bus.utmi_linestate_i, 16'(m_delta)});
          m_last = bus.utmi_linestate_i;
          mark = 1;
        end
      end
      P_RX: begin
        if (bus.utmi_rxerror_i) m_err = 1;
        if (rxa && bus.utmi_rxvalid_i) capture(bus.utmi_data_in_i);
        if (!rxa) m_phase = P_FLUSH;
      end
      P_TX: begin
        if (txv && bus.utmi_txready_i) capture(bus.utmi_data_out_i);
        if (!txv) m_phase = P_FLUSH;
      end
      P_FLUSH: begin
        if (m_bytes.size() > 0) mpush(data_word());
        m_bytes.delete();
        m_phase = P_END;
      end
      default: if (mq.size() < 4) begin
        mq.push_back({2'b11, m_err, m_trunc, 12'b0, 16'(m_cnt)});
        m_phase = P_IDLE;
      end
    endcase
    if (mark) m_delta = 0;
    else if (m_delta < 65535) m_delta++;
    if (ph0 != P_FLUSH && ph0 != P_END) begin
      m_prxa = rxa;
      m_ptxv = txv;
    end
    if (clr) begin
      m_drop = 0; m_ovf = 0;
    end else if (m_dropnow) begin
      if (m_drop < 65535) m_drop++;
      m_ovf = 1;
    end
  endtask

  task automatic step();
    if (rnd_mode) begin
      bus.outport_tready_i = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) en = ~en;
    end
    if (bus.outport_tvalid_o && bus.outport_tready_i) got.push_back(bus.outport_tdata_o);
    model_eval();
    @(posedge clk);
    #1;
    chk("tvalid", {31'b0, bus.outport_tvalid_o}, {31'b0, (mq.size() > 0)});
    if (mq.size() > 0) chk("tdata", bus.outport_tdata_o, mq[0]);
    chk("dropped", {16'b0, stat_dropped}, m_drop);
    chk("overflow", {31'b0, stat_ovf}, {31'b0, m_ovf});
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_tvalid", {31'b0, bus.outport_tvalid_o}, 0);
    chk("rst_tdata", bus.outport_tdata_o, 0);
    chk("rst_dropped", {16'b0, stat_dropped}, 0);
    chk("rst_overflow", {31'b0, stat_ovf}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rx_pkt(input logic [7:0] b[$], input int err_at);
    bus.utmi_rxactive_i = 1; bus.utmi_rxvalid_i = 0;
    step();
    foreach (b[i]) begin
      bus.utmi_rxvalid_i = 1;
      bus.utmi_data_in_i = b[i];
      bus.utmi_rxerror_i = (i == err_at);
      step();
    end
    bus.utmi_rxvalid_i = 0; bus.utmi_rxerror_i = 0; bus.utmi_rxactive_i = 0;
    step();
  endtask

  task automatic rand_rx(input int len);
    bus.utmi_rxactive_i = 1; bus.utmi_rxvalid_i = 0;
    step();
    for (int i = 0; i < len;) begin
      bus.utmi_rxvalid_i = 1'($urandom_range(0, 1));
      bus.utmi_data_in_i = 8'($urandom);
      bus.utmi_rxerror_i = ($urandom_range(0, 15) == 0);
      if (bus.utmi_rxvalid_i) i++;
      step();
    end
    bus.utmi_rxvalid_i = 0; bus.utmi_rxerror_i = 0; bus.utmi_rxactive_i = 0;
    step();
  endtask

  task automatic rand_tx(input int len);
    bus.utmi_txvalid_i = 1; bus.utmi_txready_i = 0;
    bus.utmi_data_out_i = 8'($urandom);
    step();
    for (int i = 0; i < len;) begin
      bus.utmi_txready_i  = 1'($urandom_range(0, 1));
      bus.utmi_data_out_i = 8'($urandom);
      if (bus.utmi_txready_i) i++;
      step();
    end
    bus.utmi_txvalid_i = 0; bus.utmi_txready_i = 0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.utmi_data_in_i = 0; bus.utmi_data_out_i = 0; bus.utmi_txvalid_i = 0;
    bus.utmi_txready_i = 0; bus.utmi_rxvalid_i = 0; bus.utmi_rxactive_i = 0;
    bus.utmi_rxerror_i = 0; bus.utmi_linestate_i = 2'b00; bus.outport_tready_i = 1;
    en = 1; clr = 0;
    model_reset();
    #1;
    do_reset();
    idle(3);

    // RX packet A5 01 02 03 04
    got.delete();
    rx_pkt('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04}, -1);
    idle(6);
    chk("rx_nwords", got.size(), 4);
    chk("rx_hdr", {16'h0, gw(0)[31:16]}, 32'h0000_8000);
    chk("rx_data3", gw(1), 32'h300201A5);
    chk("rx_data2", gw(2), 32'h20000403);
    chk("rx_end", gw(3), 32'hC0000005);

    // TX packet 2D 00 10 with txready toggling
    got.delete();
    bus.utmi_txvalid_i = 1; bus.utmi_data_out_i = 8'h2D; bus.utmi_txready_i = 0; step();
    bus.utmi_txready_i = 1; step();
    bus.utmi_data_out_i = 8'h00; bus.utmi_txready_i = 0; step();
    bus.utmi_txready_i = 1; step();
    bus.utmi_data_out_i = 8'h10; bus.utmi_txready_i = 0; step();
    bus.utmi_txready_i = 1; step();
    bus.utmi_txvalid_i = 0; bus.utmi_txready_i = 0; step();
    idle(6);
    chk("tx_nwords", got.size(), 3);
    chk("tx_hdr", {16'h0, gw(0)[31:16]}, 32'h0000_A000);
    chk("tx_data", gw(1), 32'h3010002D);
    chk("tx_end", gw(2), 32'hC0000003);

    // 12-byte RX packet with the sink stalled
    got.delete();
    bus.outport_tready_i = 0;
    rx_pkt('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11}, -1);
    idle(3);
    chk("ovf_dropped", {16'b0, stat_dropped}, 1);
    chk("ovf_sticky", {31'b0, stat_ovf}, 1);
    bus.outport_tready_i = 1;
    idle(8);
    chk("ovf_nwords", got.size(), 5);
    chk("ovf_data0", gw(1), 32'h30020100);
    chk("ovf_end", gw(4), 32'hD000000C);
    clr = 1; step(); clr = 0;
    chk("clr_dropped", {16'b0, stat_dropped}, 0);

    // Linestate change after 100 idle cycles
    got.delete();
    bus.utmi_linestate_i = 2'b01; step();
    idle(100);
    bus.utmi_linestate_i = 2'b00; step();
    idle(3);
    chk("ls_first", {16'h0, gw(0)[31:16]}, 32'h0000_4001);
    chk("ls_delta100", gw(got.size() - 1), 32'h40000064);
    n = got.size();
    en = 0;
    bus.utmi_linestate_i = 2'b10;
    idle(6);
    chk("ls_disabled", got.size(), n);
    bus.utmi_linestate_i = 2'b00;
    en = 1;
    idle(3);

    // rxerror mid-packet then reset: nothing of that packet survives
    bus.utmi_rxactive_i = 1; step();
    bus.utmi_rxvalid_i = 1; bus.utmi_data_in_i = 8'h11; step();
    bus.utmi_data_in_i = 8'h22; bus.utmi_rxerror_i = 1; step();
    bus.utmi_data_in_i = 8'h33; bus.utmi_rxerror_i = 0; step();
    bus.utmi_rxvalid_i = 0; bus.utmi_rxactive_i = 0;
    do_reset();
    got.delete();
    idle(3);
    rx_pkt('{8'h5A}, -1);
    idle(6);
    chk("rst_nwords", got.size(), 3);
    chk("rst_hdr", {16'h0, gw(0)[31:16]}, 32'h0000_8000);
    chk("rst_data", gw(1), 32'h1000005A);
    chk("rst_end", gw(2), 32'hC0000001);

    // Clear coinciding with a drop
    bus.outport_tready_i = 0;
    for (int i = 0; i < 4; i++) begin
      bus.utmi_linestate_i = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
    end
    bus.utmi_linestate_i = 2'b01; step();
    chk("drop_one", {16'b0, stat_dropped}, 1);
    bus.utmi_linestate_i = 2'b10; clr = 1; step(); clr = 0;
    chk("clr_wins_cnt", {16'b0, stat_dropped}, 0);
    chk("clr_wins_ovf", {31'b0, stat_ovf}, 0);
    bus.utmi_linestate_i = 2'b01; step();
    chk("drop_again", {16'b0, stat_dropped}, 1);
    bus.outport_tready_i = 1;
    idle(6);

    // Randomized traffic
    rnd_mode = 1;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 7) == 0) en = 0; else en = 1;
      case ($urandom_range(0, 4))
        0, 1:    rand_rx($urandom_range(1, 9));
        2, 3:    rand_tx($urandom_range(1, 9));
        default: bus.utmi_linestate_i = 2'($urandom_range(0, 3));
      endcase
      idle($urandom_range(0, 5));
    end
    rnd_mode = 0;
    bus.outport_tready_i = 1; en = 1; clr = 0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
